// File: rtl/idecode_pipe_if.sv
// Decode-stage bus: fetch input, write-back port and ID/EX output bundle.
// slave is the decode stage; master is whatever drives and consumes it.
interface idecode_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic [31:0]           Instruction;
    logic [DATA_W-1:0]     opcplus4;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     read_data_1;
    logic [DATA_W-1:0]     read_data_2;
    logic [DATA_W-1:0]     Sign_extend;
    logic [REG_ADDR_W-1:0] out_rs;
    logic [REG_ADDR_W-1:0] out_rt;
    logic [REG_ADDR_W-1:0] out_dest;
    logic [5:0]            out_opcode;
    logic [5:0]            out_funct;
    logic [DATA_W-1:0]     out_pcplus4;
    logic                  out_is_load;

    modport master (
        output Instruction, opcplus4, in_valid, flush,
        output wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, read_data_1, read_data_2,
        input  Sign_extend, out_rs, out_rt, out_dest,
        input  out_opcode, out_funct, out_pcplus4, out_is_load
    );

    modport slave (
        input  Instruction, opcplus4, in_valid, flush,
        input  wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, read_data_1, read_data_2,
        output Sign_extend, out_rs, out_rt, out_dest,
        output out_opcode, out_funct, out_pcplus4, out_is_load
    );
endinterface

// File: rtl/idecode_pipe.sv
// Pipelined decode stage: register file with write-back bypass, field
// decode, immediate extension and an ID/EX register with load-use stall.
module idecode_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter logic [REG_ADDR_W-1:0] LINK_REG = '1
) (
    input logic           clock,
    input logic           reset,
    idecode_pipe_if.slave bus
);
    localparam int NREG = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;

    typedef struct packed {
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc4;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic [5:0]            opcode;
        logic [5:0]            funct;
        logic                  is_load;
    } id_ex_t;

    logic [DATA_W-1:0]     rf [NREG];
    id_ex_t                d;
    id_ex_t                q;
    logic                  out_valid;
    logic [5:0]            opc;
    logic [15:0]           imm16;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_hit;
    logic                  hazard;
    logic                  advance;
    logic                  unused_shamt;

    assign opc    = bus.Instruction[31:26];
    assign imm16  = bus.Instruction[15:0];
    assign rs     = bus.Instruction[21 +: REG_ADDR_W];
    assign rt     = bus.Instruction[16 +: REG_ADDR_W];
    assign rd     = bus.Instruction[11 +: REG_ADDR_W];
    assign wb_hit = bus.wb_en && (bus.wb_addr != '0);

    assign unused_shamt = ^bus.Instruction[10:6];

    always_comb begin
        d         = '0;
        d.opcode  = opc;
        d.funct   = bus.Instruction[5:0];
        d.rs      = rs;
        d.rt      = rt;
        d.pc4     = bus.opcplus4;
        d.is_load = (opc == OP_LW);

        unique case (1'b1)
            (opc == OP_JAL):   d.dest = LINK_REG;
            (opc == OP_RTYPE): d.dest = rd;
            default:           d.dest = rt;
        endcase

        // lui keeps bit 31 replicated upward so 64-bit builds stay canonical
        unique case (1'b1)
            (opc == OP_ANDI),
            (opc == OP_ORI),
            (opc == OP_XORI): begin
                d.imm       = '0;
                d.imm[15:0] = imm16;
            end
            (opc == OP_LUI): begin
                d.imm        = {DATA_W{imm16[15]}};
                d.imm[31:16] = imm16;
                d.imm[15:0]  = '0;
            end
            default: begin
                d.imm       = {DATA_W{imm16[15]}};
                d.imm[15:0] = imm16;
            end
        endcase

        d.rd1 = (wb_hit && bus.wb_addr == rs) ? bus.wb_data : rf[rs];
        d.rd2 = (wb_hit && bus.wb_addr == rt) ? bus.wb_data : rf[rt];
    end

    assign advance = !out_valid || bus.out_ready;
    assign hazard  = out_valid && q.is_load && (q.dest != '0)
                   && (q.dest == rs || q.dest == rt);

    assign bus.in_ready = bus.flush || (advance && !hazard);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_hit) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // flush beats everything; otherwise a stalled slot drains as a bubble
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q         <= '0;
            out_valid <= 1'b0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (bus.in_valid && !hazard) begin
                q         <= d;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.read_data_1 = q.rd1;
    assign bus.read_data_2 = q.rd2;
    assign bus.Sign_extend = q.imm;
    assign bus.out_rs      = q.rs;
    assign bus.out_rt      = q.rt;
    assign bus.out_dest    = q.dest;
    assign bus.out_opcode  = q.opcode;
    assign bus.out_funct   = q.funct;
    assign bus.out_pcplus4 = q.pc4;
    assign bus.out_is_load = q.is_load;
endmodule
